// File: rtl/mul_acc_burst.sv
// mul_acc_burst: accumulates a burst of 2n-bit products (delimited by
// prod_last) into a saturating W = 2n+guard bit accumulator and presents
// one sum per burst on a valid/ready output. Signedness is latched from the
// first beat of each burst.
//
// Optional feature macro: MUL_ACC_OVERLAP_EN. When it is defined, a new
// burst may start in the same cycle the previous sum is consumed.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   prod_vld/rdy  product beat handshake
//   prod          2n-bit product
//   prod_signed   1 = prod is two's complement
//   prod_last     final beat of the burst
//   sum_vld/rdy   result handshake
//   sum           W-bit accumulated result
//   sum_ovf       saturation occurred in this burst
//   sum_err       signedness changed within this burst
//   sum_cnt       beats in this burst, saturating at all-ones
module mul_acc_burst #(
   parameter int unsigned n     = 8,
   parameter int unsigned guard = 4,
   parameter int unsigned cnt_w = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   prod_vld,
   output logic                   prod_rdy,
   input  logic [2*n-1:0]         prod,
   input  logic                   prod_signed,
   input  logic                   prod_last,
   output logic                   sum_vld,
   input  logic                   sum_rdy,
   output logic [2*n+guard-1:0]   sum,
   output logic                   sum_ovf,
   output logic                   sum_err,
   output logic [cnt_w-1:0]       sum_cnt
);

   localparam int unsigned P = 2 * n;
   localparam int unsigned W = 2 * n + guard;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t            state, state_nxt;
   logic              take, start, mode, mode_eff, clamp;
   logic [W-1:0]      acc, ext, acc_add;
   logic [W:0]        raw;
   logic [cnt_w-1:0]  cnt;
   logic              ovf, err;

   // Ready: low in reset and while a sum is pending (unless overlap allowed)
   always_comb begin
      prod_rdy = 1'b1;
      if (rst) begin
         prod_rdy = 1'b0;
      end else if (state == HOLD) begin
`ifdef MUL_ACC_OVERLAP_EN
         prod_rdy = sum_rdy;
`else
         prod_rdy = 1'b0;
`endif
      end
   end

   assign take     = prod_vld && prod_rdy;
   // Any accepted beat outside ACC opens a new burst
   assign start    = (state != ACC);
   assign mode_eff = start ? prod_signed : mode;
   assign ext      = mode_eff ? {{guard{prod[P-1]}}, prod} : {{guard{1'b0}}, prod};

   // W+1-bit add with clamp to the representable range of the latched mode
   always_comb begin
      clamp   = 1'b0;
      acc_add = '0;
      if (mode) begin
         raw     = {acc[W-1], acc} + {ext[W-1], ext};
         clamp   = raw[W] ^ raw[W-1];
         acc_add = clamp ? (raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                         : raw[W-1:0];
      end else begin
         raw     = {1'b0, acc} + {1'b0, ext};
         clamp   = raw[W];
         acc_add = clamp ? {W{1'b1}} : raw[W-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (take) state_nxt = prod_last ? HOLD : ACC;
         ACC:  if (take && prod_last) state_nxt = HOLD;
         HOLD: begin
            if (sum_rdy) begin
               state_nxt = IDLE;
`ifdef MUL_ACC_OVERLAP_EN
               if (take) state_nxt = prod_last ? HOLD : ACC;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator, beat counter and per-burst flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         mode <= 1'b0;
         ovf  <= 1'b0;
         err  <= 1'b0;
      end else if (take) begin
         if (start) begin
            acc  <= ext;
            cnt  <= cnt_w'(1);
            mode <= prod_signed;
            ovf  <= 1'b0;
            err  <= 1'b0;
         end else begin
            acc <= acc_add;
            if (cnt != {cnt_w{1'b1}}) cnt <= cnt + cnt_w'(1);
            ovf <= ovf | clamp;
            err <= err | (prod_signed != mode);
         end
      end
   end

   assign sum_vld = (state == HOLD);
   assign sum     = acc;
   assign sum_ovf = ovf;
   assign sum_err = err;
   assign sum_cnt = cnt;

endmodule

// File: tb/tb_mul_acc_burst.sv
// Directed self-checking bench for mul_acc_burst (n=4, guard=4, W=12,
// cnt_w=4 so long bursts also exercise beat-count saturation at 15).
module tb_mul_acc_burst;

   localparam int unsigned N  = 4;
   localparam int unsigned G  = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned W  = 2 * N + G;

   logic            clk = 1'b0;
   logic            rst;
   logic            prod_vld, prod_rdy, prod_signed, prod_last;
   logic [2*N-1:0]  prod;
   logic            sum_vld, sum_rdy, sum_ovf, sum_err;
   logic [W-1:0]    sum;
   logic [CW-1:0]   sum_cnt;

   int checks = 0;
   int errors = 0;

   mul_acc_burst #(.n(N), .guard(G), .cnt_w(CW)) dut (
      .clk(clk), .rst(rst),
      .prod_vld(prod_vld), .prod_rdy(prod_rdy), .prod(prod),
      .prod_signed(prod_signed), .prod_last(prod_last),
      .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum(sum),
      .sum_ovf(sum_ovf), .sum_err(sum_err), .sum_cnt(sum_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer one beat and wait (bounded) until it is accepted
   task automatic beat(input logic [7:0] p, input logic s, input logic last);
      int t = 0;
      prod_vld = 1'b1; prod = p; prod_signed = s; prod_last = last;
      while (!prod_rdy && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!prod_rdy) check("rdy_timeout", 32'(prod_rdy), 32'd1);
      @(posedge clk); #1;
      prod_vld = 1'b0; prod_last = 1'b0;
   endtask

   // Back-to-back burst of identical beats; sum_vld must follow the last one
   task automatic burst(input string tag, input logic [7:0] p, input logic s, input int num);
      for (int i = 0; i < num; i++) beat(p, s, (i == num - 1));
      check({tag, "_latency"}, 32'(sum_vld), 32'd1);
   endtask

   task automatic take_sum(input string tag, input logic [W-1:0] es, input logic eo,
                           input logic ee, input logic [CW-1:0] ec);
      check({tag, "_vld"}, 32'(sum_vld), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_ovf"}, 32'(sum_ovf), 32'(eo));
      check({tag, "_err"}, 32'(sum_err), 32'(ee));
      check({tag, "_cnt"}, 32'(sum_cnt), 32'(ec));
      sum_rdy = 1'b1;
      @(posedge clk); #1;
      sum_rdy = 1'b0;
      check({tag, "_drop"}, 32'(sum_vld), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; prod_vld = 1'b0; prod = '0; prod_signed = 1'b0;
      prod_last = 1'b0; sum_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy", 32'(prod_rdy), 32'd0);
      check("rst_vld", 32'(sum_vld), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cnt", 32'(sum_cnt), 32'd0);
      check("rst_flags", 32'({sum_ovf, sum_err}), 32'd0);
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 32'(prod_rdy), 32'd1);
      @(posedge clk); #1;

      // Unsigned 3 x 225 = 675, then backpressure for 5 cycles
      burst("u3", 8'hE1, 1'b0, 3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_vld", 32'(sum_vld), 32'd1);
         check("bp_sum", 32'(sum), 32'd675);
         check("bp_rdy", 32'(prod_rdy), 32'd0);
      end
      take_sum("u3", 12'd675, 1'b0, 1'b0, 4'd3);

      // Signed 3 x -56 = -168
      burst("s3", 8'hC8, 1'b1, 3);
      take_sum("s3", 12'hF58, 1'b0, 1'b0, 4'd3);

      // Single-beat signed 0x40
      burst("s1", 8'h40, 1'b1, 1);
      take_sum("s1", 12'd64, 1'b0, 1'b0, 4'd1);

      // Unsigned saturation: 19 x 225 = 4275 -> 4095; count saturates at 15
      burst("usat", 8'hE1, 1'b0, 19);
      take_sum("usat", 12'hFFF, 1'b1, 1'b0, 4'd15);

      // Signed saturation: 37 x -56 = -2072 -> -2048
      burst("ssat", 8'hC8, 1'b1, 37);
      take_sum("ssat", 12'h800, 1'b1, 1'b0, 4'd15);

      // Flags clear on the next burst
      burst("u1", 8'h05, 1'b0, 1);
      take_sum("u1", 12'd5, 1'b0, 1'b0, 4'd1);

      // Mode mismatch: both beats accumulate unsigned (200 + 200)
      beat(8'hC8, 1'b0, 1'b0);
      beat(8'hC8, 1'b1, 1'b1);
      check("mm_latency", 32'(sum_vld), 32'd1);
      take_sum("mm", 12'd400, 1'b0, 1'b1, 4'd2);

      // Beat offered as the sum is consumed
      burst("ov_a", 8'h03, 1'b0, 1);
      sum_rdy = 1'b1; prod_vld = 1'b1; prod = 8'h09; prod_signed = 1'b0; prod_last = 1'b1;
      #1;
`ifdef MUL_ACC_OVERLAP_EN
      check("ov_rdy", 32'(prod_rdy), 32'd1);
      @(posedge clk); #1;
      sum_rdy = 1'b0; prod_vld = 1'b0; prod_last = 1'b0;
      check("ov_nobubble", 32'(sum_vld), 32'd1);
`else
      check("ov_rdy", 32'(prod_rdy), 32'd0);
      @(posedge clk); #1;
      sum_rdy = 1'b0;
      check("ov_bubble", 32'(sum_vld), 32'd0);
      beat(8'h09, 1'b0, 1'b1);
`endif
      take_sum("ov_b", 12'd9, 1'b0, 1'b0, 4'd1);

      // Reset two beats into a burst discards it
      beat(8'h03, 1'b0, 1'b0);
      beat(8'h04, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_sum", 32'(sum), 32'd0);
      check("mrst_cnt", 32'(sum_cnt), 32'd0);
      check("mrst_vld", 32'(sum_vld), 32'd0);
      check("mrst_rdy", 32'(prod_rdy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("mrst_idle", 32'(sum_vld), 32'd0);
      burst("r7", 8'h07, 1'b0, 1);
      take_sum("r7", 12'd7, 1'b0, 1'b0, 4'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
